// File: rtl/uart_tx_if.sv
// Byte-write and serial-status bundle between the CPU peripheral logic and uart_tx.
interface uart_tx_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          tx_done;
  logic          uart_out;

  modport master (
    output wr_en, wr_data,
    input  full, fifo_count, busy, tx_done, uart_out
  );

  modport slave (
    input  wr_en, wr_data,
    output full, fifo_count, busy, tx_done, uart_out
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a small FIFO; the baud rate is set by CLKS_PER_BIT.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          uart_q, uart_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, baud_last, fifo_empty;
  logic [2:0]    bit_nxt;

  assign fifo_empty = (count_q == '0);
  assign push       = bus.wr_en && (count_q != CW'(FIFO_DEPTH));
  assign baud_last  = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign bit_nxt    = bit_q + 3'd1;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    uart_d  = uart_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        uart_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
          uart_d  = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
          uart_d  = shift_q[0];
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            uart_d  = 1'b1;
          end else begin
            bit_d  = bit_nxt;
            uart_d = shift_q[bit_nxt];
          end
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // A queued byte chains straight into its start bit with no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
            uart_d  = 1'b0;
          end else begin
            state_d = IDLE;
            uart_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        uart_d  = 1'b1;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      uart_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      uart_q   <= uart_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage needs no reset: the count and pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.full       = (count_q == CW'(FIFO_DEPTH));
  assign bus.fifo_count = count_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.tx_done    = (state_q == STOP) && baud_last;
  assign bus.uart_out   = uart_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle line/busy/tx_done checks against a frame-level model.
module tb_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();
  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Model: bytes in exp_q are sent back-to-back; k counts edges after the first write edge.
  function automatic logic m_line(int k);
    int f, pos;
    if (k < 1) return 1'b1;
    f = (k - 1) / FRAME;
    if (f >= exp_q.size()) return 1'b1;
    pos = ((k - 1) % FRAME) / CPB;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return exp_q[f][pos-1];
  endfunction

  function automatic logic m_busy(int k);
    return (k >= 1) && (((k - 1) / FRAME) < exp_q.size());
  endfunction

  function automatic logic m_done(int k);
    return m_busy(k) && (((k - 1) % FRAME) == FRAME - 1);
  endfunction

  task automatic test_reset();
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.uart_out !== 1'b1) begin errors++; $display("FAIL reset_uart_out got=%b exp=1", bus.uart_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done got=%b exp=0", bus.tx_done); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.fifo_count); end
    repeat (4) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    exp_q = {8'hA5};
    for (int k = 0; k <= FRAME + 5; k++) begin
      bus.wr_en = (k == 0);
      bus.wr_data = 8'hA5;
      @(negedge clk);
      checks++; if (bus.uart_out !== m_line(k)) begin errors++; $display("FAIL single_line k=%0d got=%b exp=%b", k, bus.uart_out, m_line(k)); end
      checks++; if (bus.busy !== m_busy(k)) begin errors++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, bus.busy, m_busy(k)); end
      checks++; if (bus.tx_done !== m_done(k)) begin errors++; $display("FAIL single_done k=%0d got=%b exp=%b", k, bus.tx_done, m_done(k)); end
    end
  endtask

  task automatic test_overflow();
    int done_cnt = 0;
    exp_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    for (int k = 0; k <= 5 * FRAME + 5; k++) begin
      bus.wr_en = (k < 6);
      bus.wr_data = 8'(k + 1);
      @(negedge clk);
      if (bus.tx_done === 1'b1) done_cnt++;
      checks++; if (bus.uart_out !== m_line(k)) begin errors++; $display("FAIL ovf_line k=%0d got=%b exp=%b", k, bus.uart_out, m_line(k)); end
      checks++; if (bus.busy !== m_busy(k)) begin errors++; $display("FAIL ovf_busy k=%0d got=%b exp=%b", k, bus.busy, m_busy(k)); end
      checks++; if (bus.tx_done !== m_done(k)) begin errors++; $display("FAIL ovf_done k=%0d got=%b exp=%b", k, bus.tx_done, m_done(k)); end
      if (k == 5 || k == 40) begin
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full k=%0d got=%b exp=1", k, bus.full); end
        checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count k=%0d got=%0d exp=4", k, bus.fifo_count); end
      end
      if (k == 41) begin
        checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL ovf_count_pop got=%0d exp=3", bus.fifo_count); end
      end
    end
    checks++; if (done_cnt != 5) begin errors++; $display("FAIL ovf_done_pulses got=%0d exp=5", done_cnt); end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      int n = $urandom_range(1, 5);
      exp_q = {};
      for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom));
      for (int k = 0; k <= n * FRAME + 3; k++) begin
        bus.wr_en = (k < n);
        bus.wr_data = (k < n) ? exp_q[k] : 8'h00;
        @(negedge clk);
        checks++; if (bus.uart_out !== m_line(k)) begin errors++; $display("FAIL b2b_line r=%0d k=%0d got=%b exp=%b", r, k, bus.uart_out, m_line(k)); end
        checks++; if (bus.busy !== m_busy(k)) begin errors++; $display("FAIL b2b_busy r=%0d k=%0d got=%b exp=%b", r, k, bus.busy, m_busy(k)); end
        checks++; if (bus.tx_done !== m_done(k)) begin errors++; $display("FAIL b2b_done r=%0d k=%0d got=%b exp=%b", r, k, bus.tx_done, m_done(k)); end
      end
    end
  endtask

  task automatic test_push_pop();
    exp_q = {8'($urandom), 8'($urandom), 8'($urandom)};
    for (int k = 0; k <= 3 * FRAME + 3; k++) begin
      bus.wr_en = (k == 0) || (k == 2) || (k == 41);
      bus.wr_data = (k == 0) ? exp_q[0] : (k == 2) ? exp_q[1] : exp_q[2];
      @(negedge clk);
      checks++; if (bus.uart_out !== m_line(k)) begin errors++; $display("FAIL pp_line k=%0d got=%b exp=%b", k, bus.uart_out, m_line(k)); end
      checks++; if (bus.busy !== m_busy(k)) begin errors++; $display("FAIL pp_busy k=%0d got=%b exp=%b", k, bus.busy, m_busy(k)); end
      if (k == 40 || k == 41) begin
        checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL pp_count k=%0d got=%0d exp=1", k, bus.fifo_count); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    exp_q = {8'h3C, 8'($urandom), 8'($urandom)};
    for (int k = 0; k <= 18; k++) begin
      bus.wr_en = (k < 3);
      bus.wr_data = (k < 3) ? exp_q[k] : 8'h00;
      @(negedge clk);
      checks++; if (bus.uart_out !== m_line(k)) begin errors++; $display("FAIL mid_line k=%0d got=%b exp=%b", k, bus.uart_out, m_line(k)); end
      if (k == 2) begin
        checks++; if (bus.fifo_count !== 3'd2) begin errors++; $display("FAIL mid_count_pre got=%0d exp=2", bus.fifo_count); end
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.uart_out !== 1'b1) begin errors++; $display("FAIL mid_rst_line got=%b exp=1", bus.uart_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL mid_rst_count got=%0d exp=0", bus.fifo_count); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.wr_en = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      checks++; if (bus.uart_out !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_quiet k=%0d got=%b/%b exp=1/0", k, bus.uart_out, bus.busy); end
    end
    exp_q = {8'($urandom)};
    for (int k = 0; k <= FRAME + 3; k++) begin
      bus.wr_en = (k == 0);
      bus.wr_data = exp_q[0];
      @(negedge clk);
      checks++; if (bus.uart_out !== m_line(k)) begin errors++; $display("FAIL mid_after_line k=%0d got=%b exp=%b", k, bus.uart_out, m_line(k)); end
    end
  endtask

  task automatic test_zeros_ones();
    exp_q = {8'h00, 8'hFF};
    for (int k = 0; k <= 2 * FRAME + 3; k++) begin
      bus.wr_en = (k < 2);
      bus.wr_data = (k == 0) ? 8'h00 : 8'hFF;
      @(negedge clk);
      checks++; if (bus.uart_out !== m_line(k)) begin errors++; $display("FAIL zo_line k=%0d got=%b exp=%b", k, bus.uart_out, m_line(k)); end
      checks++; if (bus.tx_done !== m_done(k)) begin errors++; $display("FAIL zo_done k=%0d got=%b exp=%b", k, bus.tx_done, m_done(k)); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_push_pop();
    test_reset_midframe();
    test_zeros_ones();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter; the transmit counterpart of the existing UART receiver in cpu_perefery.
- The CPU-side peripheral logic pushes bytes into a small internal FIFO, and the block serialises them onto uart_out.
- Start bit, 8 data bits LSB first, one stop bit, no parity; the baud rate is set by a clock-divider parameter.
- Lets the MIPS core send bytes off-chip without software bit-banging.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (434 = 50 MHz / 115200 baud); minimum 2.
- FIFO_DEPTH, 4, transmit FIFO entries; must be a power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- wr_en  input  1  write strobe; pushes wr_data into the FIFO when full is 0.
- wr_data  input  8  byte to transmit.
- full  output  1  FIFO full; writes are ignored while this is 1.
- fifo_count  output  clog2(FIFO_DEPTH)+1  number of bytes waiting in the FIFO (excludes the byte being shifted).
- busy  output  1  1 whenever the FSM is not in IDLE.
- tx_done  output  1  one-cycle pulse at the end of each stop bit.
- uart_out  output  1  serial line, registered, idle high.

Behaviour:
- Reset (asynchronous, immediate): uart_out=1, busy=0, tx_done=0, full=0, fifo_count=0, FSM=IDLE, all counters 0. Any frame in flight is aborted and FIFO contents are discarded.
- FIFO:
  - Push occurs on an edge where wr_en=1 and full=0.
  - A push while full is dropped silently; contents and count are unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop in one cycle is legal: count is unchanged and both take effect.
  - full = (count == FIFO_DEPTH). A written byte is counted in the cycle after the write edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_out=1. If the FIFO is non-empty at an edge: pop the head into the 8-bit shift register, clear the baud counter, go to START, and drive uart_out=0 from that edge. Start-bit latency is therefore exactly one clk after the write edge when the FIFO was empty.
  - START: hold uart_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0 and uart_out=shift[0].
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7 completes, go to STOP with uart_out=1.
  - STOP: hold uart_out=1 for CLKS_PER_BIT cycles. On its final cycle tx_done=1 for exactly one clk.
    - If the FIFO is non-empty at that edge: pop, go directly to START, no idle gap.
    - Otherwise: go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles, measured from the uart_out falling edge to the next possible start bit.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps at the end of each bit. It is reset whenever a state is entered.
- The shift register is loaded only on a pop and is unaffected by FIFO writes during a frame.
- uart_out is glitch-free: it comes straight from a flop with no combinational path from inputs.
- busy=1 in START, DATA and STOP, including the back-to-back STOP->START transition.
- The byte in the shift register does not count toward full, so up to FIFO_DEPTH+1 bytes can be accepted while idle.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Single byte: rst high for 4 clks, then write 0xA5 at edge N.
   - uart_out falls at N+1.
   - Per 4-clk bit, line reads 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop).
   - tx_done pulses at N+40; busy drops and uart_out stays 1 from N+41.
2. Overflow: write 0x01..0x06 on 6 consecutive edges starting at N.
   - full=1 from N+5, fifo_count=4.
   - 0x06 is dropped.
   - Serial output is 0x01,0x02,0x03,0x04,0x05 back-to-back: five frames, 200 clks, uart_out never idle between frames, five tx_done pulses.
3. Simultaneous push/pop: FIFO holds 1 byte while the STOP bit of the previous frame ends; assert wr_en on that same edge.
   - fifo_count stays 1.
   - Both bytes are transmitted in order.
4. Reset mid-frame: assert rst asynchronously during data bit 3 of 0x3C with 2 bytes queued.
   - uart_out=1, busy=0, fifo_count=0 immediately, without waiting for a clk edge.
   - After release, no transmission occurs until a new write.
5. All-zero and all-one data: send 0x00 then 0xFF.
   - Line is low for 36 clks, then high for 4 clks (stop).
   - Next frame: start low 4 clks, then high 36 clks.
   - Edges align exactly on 4-clk boundaries.
